// File: rtl/fifo_valrdy.sv
// fifo_valrdy: parametrised val/rdy FIFO with first-word-fall-through output,
// occupancy count, programmable almost-full/almost-empty flags and a
// synchronous clear. Pointers wrap by compare, so any DEPTH >= 2 is supported.
module fifo_valrdy #(
  parameter int DEPTH    = 4,
  parameter int NBITS    = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [NBITS-1:0]           in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [NBITS-1:0]           out_msg,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Reject nonsensical configurations while elaborating.
  if (DEPTH < 2) begin : g_depth_chk
    $error("fifo_valrdy: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("fifo_valrdy: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_chk
    $error("fifo_valrdy: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Advance a pointer, wrapping at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake qualifiers and status outputs, all derived from registered count.
  assign in_rdy       = (count_q != CW'(DEPTH));
  assign out_val      = (count_q != '0);
  assign push         = in_val & in_rdy;
  assign pop          = out_val & out_rdy;
  assign wr_en        = push & ~clear;
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign out_msg      = out_val ? mem_q[rptr_q] : '0;

  // Next-state for pointers and occupancy; clear overrides push and pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = next_ptr(wptr_q);
      if (pop)  rptr_d = next_ptr(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count/out_val gate stale contents.
    if (wr_en) mem_q[wptr_q] <= in_msg;
  end

endmodule

// File: tb/tb_fifo_valrdy.sv
// tb_fifo_valrdy: three fifo_valrdy instances (DEPTH 3, 5, 4) share one
// stimulus stream; each has its own scoreboard model (circular buffer) that
// predicts count, handshakes, flags and head data every cycle.
module tb_fifo_valrdy;

  localparam int NB = 16;
  localparam int NI = 3;
  localparam int DEP [NI] = '{3, 5, 4};
  localparam int AFL [NI] = '{2, 2, 3};
  localparam int AEL [NI] = '{1, 3, 1};

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_val;
  logic [NB-1:0] in_msg;
  logic          out_rdy;

  logic          in_rdy0, out_val0, af0, ae0;
  logic [NB-1:0] out_msg0;
  logic [1:0]    cnt0;
  logic          in_rdy1, out_val1, af1, ae1;
  logic [NB-1:0] out_msg1;
  logic [2:0]    cnt1;
  logic          in_rdy2, out_val2, af2, ae2;
  logic [NB-1:0] out_msg2;
  logic [2:0]    cnt2;

  int checks = 0;
  int errors = 0;

  // Scoreboard: per-instance circular buffer of accepted messages.
  logic [NB-1:0] m_mem  [NI][5];
  int            m_head [NI] = '{0, 0, 0};
  int            m_size [NI] = '{0, 0, 0};

  fifo_valrdy #(.DEPTH(3), .NBITS(NB)) u_d3 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_val(in_val), .in_rdy(in_rdy0), .in_msg(in_msg),
    .out_val(out_val0), .out_rdy(out_rdy), .out_msg(out_msg0),
    .count(cnt0), .almost_full(af0), .almost_empty(ae0));

  fifo_valrdy #(.DEPTH(5), .NBITS(NB), .AF_LEVEL(2), .AE_LEVEL(3)) u_d5 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_val(in_val), .in_rdy(in_rdy1), .in_msg(in_msg),
    .out_val(out_val1), .out_rdy(out_rdy), .out_msg(out_msg1),
    .count(cnt1), .almost_full(af1), .almost_empty(ae1));

  fifo_valrdy #(.DEPTH(4), .NBITS(NB), .AF_LEVEL(3), .AE_LEVEL(1)) u_d4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_val(in_val), .in_rdy(in_rdy2), .in_msg(in_msg),
    .out_val(out_val2), .out_rdy(out_rdy), .out_msg(out_msg2),
    .count(cnt2), .almost_full(af2), .almost_empty(ae2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every instance's outputs against its model.
  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic [31:0]   o_cnt;
      logic          o_irdy, o_oval, o_af, o_ae;
      logic [NB-1:0] o_msg, e_msg;
      case (k)
        0:       begin o_cnt = 32'(cnt0); o_irdy = in_rdy0; o_oval = out_val0;
                       o_msg = out_msg0; o_af = af0; o_ae = ae0; end
        1:       begin o_cnt = 32'(cnt1); o_irdy = in_rdy1; o_oval = out_val1;
                       o_msg = out_msg1; o_af = af1; o_ae = ae1; end
        default: begin o_cnt = 32'(cnt2); o_irdy = in_rdy2; o_oval = out_val2;
                       o_msg = out_msg2; o_af = af2; o_ae = ae2; end
      endcase
      e_msg = (m_size[k] != 0) ? m_mem[k][m_head[k]] : '0;
      check($sformatf("d%0d_count", DEP[k]),   o_cnt,  32'(m_size[k]));
      check($sformatf("d%0d_in_rdy", DEP[k]),  32'(o_irdy), 32'(m_size[k] != DEP[k]));
      check($sformatf("d%0d_out_val", DEP[k]), 32'(o_oval), 32'(m_size[k] != 0));
      check($sformatf("d%0d_out_msg", DEP[k]), 32'(o_msg),  32'(e_msg));
      check($sformatf("d%0d_afull", DEP[k]),   32'(o_af),   32'(m_size[k] >= AFL[k]));
      check($sformatf("d%0d_aempty", DEP[k]),  32'(o_ae),   32'(m_size[k] <= AEL[k]));
    end
  endtask

  // Advance the models by the transfer the coming rising edge will perform.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit do_push, do_pop;
      if (clear) begin
        m_head[k] = 0;
        m_size[k] = 0;
      end else begin
        do_push = in_val && (m_size[k] != DEP[k]);
        do_pop  = out_rdy && (m_size[k] != 0);
        if (do_push) m_mem[k][(m_head[k] + m_size[k]) % DEP[k]] = in_msg;
        if (do_pop)  m_head[k] = (m_head[k] + 1) % DEP[k];
        m_size[k] = m_size[k] + int'(do_push) - int'(do_pop);
      end
    end
  endtask

  // Mid-cycle sampling: inputs are stable, outputs settled from the last edge.
  always @(negedge clk) begin
    check_all();
    if (rst) model_step();
  end

  // Asynchronous reset empties every model immediately.
  always @(negedge rst) begin
    for (int k = 0; k < NI; k++) begin
      m_head[k] = 0;
      m_size[k] = 0;
    end
  end

  // Apply one cycle of stimulus, changing inputs just after the rising edge.
  task automatic cyc(input logic v, input logic [NB-1:0] m, input logic r, input logic c);
    in_val  = v;
    in_msg  = m;
    out_rdy = r;
    clear   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill past full with the consumer stalled, then pop in order.
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0);
    cyc(1'b1, 16'hCCCC, 1'b0, 1'b0);
    cyc(1'b1, 16'hDDDD, 1'b0, 1'b0);
    drain();

    // Push offered at full together with a pop: blocked this cycle, taken next.
    cyc(1'b1, 16'h0101, 1'b0, 1'b0);
    cyc(1'b1, 16'h0202, 1'b0, 1'b0);
    cyc(1'b1, 16'h0303, 1'b0, 1'b0);
    cyc(1'b1, 16'h1111, 1'b1, 1'b0);
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    drain();

    // Steady streaming: count holds at 1, pointers wrap repeatedly.
    cyc(1'b1, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    drain();

    // Walk occupancy up one entry at a time, then down, exercising both flags.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
    end

    // Clear wins over a simultaneous push and pop.
    cyc(1'b1, 16'h5001, 1'b0, 1'b0);
    cyc(1'b1, 16'h5002, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b1, 1'b1);
    cyc(1'b1, 16'h6666, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset between edges with data queued.
    cyc(1'b1, 16'h7001, 1'b0, 1'b0);
    cyc(1'b1, 16'h7002, 1'b0, 1'b0);
    cyc(1'b1, 16'h7003, 1'b0, 1'b0);
    in_val = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Random traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
